// File: rtl/poly_accel_pkg.sv
// rtl/poly_accel_pkg.sv - shared state encoding, mode constants and cube-root sizing helper
package poly_accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_SQR = 1'b0;
    localparam logic MODE_MUL = 1'b1;

    // Number of restoring cube-root iterations, equal to the root width in bits
    function automatic int cbrt_iter(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/poly_accel_cbrt.sv
// rtl/poly_accel_cbrt.sv - iterative restoring integer cube root, one root bit per cycle
module poly_accel_cbrt
    import poly_accel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [WIDTH-1:0]               x_bi,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [cbrt_iter(WIDTH)-1:0]    y_bo
);

    localparam int K  = cbrt_iter(WIDTH);
    localparam int XW = 3 * K;
    localparam int CW = XW + 2;
    localparam int IW = $clog2(K + 1);

    logic [XW-1:0] x_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] y2;
    logic [CW-1:0] m;
    logic [CW-1:0] xs;
    logic [CW-1:0] msh;
    logic [31:0]   sh;
    logic          ge;

    // One restoring step: the candidate term is compared against x>>s, which
    // keeps the comparison inside 3K+2 bits instead of shifting the term up.
    always_comb begin
        sh  = 32'(idx_q) * 32'd3;
        y2  = {{(CW-K-1){1'b0}}, y_bo, 1'b0};
        m   = (y2 * CW'(3)) * (y2 + CW'(1)) + CW'(1);
        xs  = {2'b00, x_q} >> sh;
        ge  = (xs >= m);
        msh = m << sh;
    end

    // Iteration state: load on start, then walk s from 3*(K-1) down to 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_bo   <= '0;
            idx_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else if (start_i) begin
            x_q    <= XW'(x_bi);
            y_bo   <= '0;
            idx_q  <= IW'(K - 1);
            busy_o <= 1'b1;
            done_o <= 1'b0;
        end else if (busy_o) begin
            if (ge) begin
                x_q <= x_q - msh[XW-1:0];
            end
            y_bo <= y2[K-1:0] + K'(ge);
            if (idx_q == '0) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
            end else begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_accel.sv
// rtl/poly_accel.sv - iterative y = (a*a | a*b) + cbrt(b); optional POLY_ACCEL_CYCLE_CNT_EN adds cyc_bo
module poly_accel
    import poly_accel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
`ifdef POLY_ACCEL_CYCLE_CNT_EN
    output logic [15:0]          cyc_bo,
`endif
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   y_bo
);

    localparam int CBRT_ITER = cbrt_iter(WIDTH);
    localparam int YW        = 2 * WIDTH;
    localparam int CNT_W     = $clog2(WIDTH);

    state_t                 state_q;
    logic [YW-1:0]          mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [YW-1:0]          prod_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   launch;
    logic                   cbrt_busy;
    logic                   cbrt_done;
    logic [CBRT_ITER-1:0]   cbrt_root;

    assign launch = (state_q == ST_IDLE) && start_i;

    poly_accel_cbrt #(
        .WIDTH (WIDTH)
    ) u_cbrt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (launch),
        .x_bi    (b_bi),
        .busy_o  (cbrt_busy),
        .done_o  (cbrt_done),
        .y_bo    (cbrt_root)
    );

    // Control FSM with the LSB-first shift-add multiplier folded into RUN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            y_bo     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_o <= 1'b0;
                    if (start_i) begin
                        mcand_q  <= YW'(a_bi);
                        mplier_q <= (mode_i == MODE_MUL) ? b_bi : a_bi;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        busy_o   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1) && cbrt_done && !cbrt_busy) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    y_bo    <= prod_q + YW'(cbrt_root);
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef POLY_ACCEL_CYCLE_CNT_EN
    logic [15:0] cyc_run_q;

    // Saturating RUN+DONE cycle count, published alongside each result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_run_q <= '0;
            cyc_bo    <= '0;
        end else if (launch) begin
            cyc_run_q <= '0;
        end else if (state_q == ST_RUN || state_q == ST_DONE) begin
            cyc_run_q <= (cyc_run_q == 16'hFFFF) ? cyc_run_q : cyc_run_q + 16'd1;
            if (state_q == ST_DONE) begin
                cyc_bo <= (cyc_run_q == 16'hFFFF) ? cyc_run_q : cyc_run_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_poly_accel.sv
// tb/tb_poly_accel.sv - self-checking bench for poly_accel (WIDTH=8 and WIDTH=16 instances)
module tb_poly_accel;

    localparam int W  = 8;
    localparam int W2 = 16;
    localparam int P  = W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            mode = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            busy;
    logic            valid;
    logic [2*W-1:0]  y;

    logic            start16 = 1'b0;
    logic            mode16 = 1'b0;
    logic [W2-1:0]   a16 = '0;
    logic [W2-1:0]   b16 = '0;
    logic            busy16;
    logic            valid16;
    logic [2*W2-1:0] y16;

`ifdef POLY_ACCEL_CYCLE_CNT_EN
    logic [15:0]     cyc;
    logic [15:0]     cyc16;
`endif

    poly_accel #(.WIDTH(W)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .mode_i  (mode),
        .a_bi    (a),
        .b_bi    (b),
`ifdef POLY_ACCEL_CYCLE_CNT_EN
        .cyc_bo  (cyc),
`endif
        .busy_o  (busy),
        .valid_o (valid),
        .y_bo    (y)
    );

    poly_accel #(.WIDTH(W2)) u_dut16 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start16),
        .mode_i  (mode16),
        .a_bi    (a16),
        .b_bi    (b16),
`ifdef POLY_ACCEL_CYCLE_CNT_EN
        .cyc_bo  (cyc16),
`endif
        .busy_o  (busy16),
        .valid_o (valid16),
        .y_bo    (y16)
    );

    int vectors = 0;
    int errors  = 0;

    function automatic longint unsigned ref_y(input bit m, input longint unsigned av,
                                              input longint unsigned bv);
        longint unsigned p;
        longint unsigned r;
        p = m ? av * bv : av * av;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= bv) r++;
        return p + r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation: latency, busy span, result, single-cycle pulse
    task automatic run8(input bit m, input int unsigned av, input int unsigned bv, input string tag);
        longint unsigned exp;
        int lat;
        int busy_n;
        bit got;
        exp = ref_y(m, av, bv);
        @(negedge clk);
        mode = m; a = av[W-1:0]; b = bv[W-1:0]; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
        busy_n = busy ? 1 : 0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_n++;
            if (valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_busy_span"}, 64'(busy_n), 64'(W + 1));
        check({tag, "_y"}, 64'(y), exp);
`ifdef POLY_ACCEL_CYCLE_CNT_EN
        check({tag, "_cyc"}, 64'(cyc), 64'(W + 1));
`endif
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(valid), 64'd0);
    endtask

    bit          om[64];
    int unsigned oa[64];
    int unsigned ob[64];

    initial begin
        int pulses;
        int lat16;
        bit exp_v;

        #1 rst = 1'b1;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_y", 64'(y), 64'd0);
        check("reset_y16", 64'(y16), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run8(1'b0, 5, 27, "sqr_5_27");
        run8(1'b0, 255, 255, "sqr_255_255");
        run8(1'b1, 12, 100, "mul_12_100");
        run8(1'b1, 0, 0, "mul_0_0");
        run8(1'b1, 1, 1, "mul_1_1");
        for (int i = 0; i < 6; i++) begin
            run8(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255), "rand");
        end

        // start held high with operands changing every cycle
        pulses = 0;
        for (int c = 0; c < 4 * P; c++) begin
            om[c] = 1'($urandom);
            oa[c] = $urandom_range(0, 255);
            ob[c] = $urandom_range(0, 255);
            mode = om[c]; a = oa[c][W-1:0]; b = ob[c][W-1:0]; start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            exp_v = (c >= W + 1) && (((c - (W + 1)) % P) == 0);
            check("stream_valid", 64'(valid), 64'(exp_v));
            if (exp_v) begin
                pulses++;
                check("stream_y", 64'(y), ref_y(om[c-W-1], oa[c-W-1], ob[c-W-1]));
            end
        end
        start = 1'b0;
        check("stream_pulses", 64'(pulses), 64'd4);

        // asynchronous reset four cycles into RUN
        @(negedge clk);
        mode = 1'b1; a = 8'd200; b = 8'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_y", 64'(y), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < W + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) pulses++;
        end
        check("abort_no_valid", 64'(pulses), 64'd0);
        run8(1'b1, 200, 200, "after_abort");

        // WIDTH=16 instance
        @(negedge clk);
        mode16 = 1'b0; a16 = 16'd1000; b16 = 16'd4096; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        lat16 = 0;
        for (int i = 1; i <= 60 && lat16 == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid16) lat16 = i;
        end
        check("w16_latency", 64'(lat16), 64'(W2 + 1));
        check("w16_y", 64'(y16), ref_y(1'b0, 1000, 4096));
`ifdef POLY_ACCEL_CYCLE_CNT_EN
        check("w16_cyc", 64'(cyc16), 64'(W2 + 1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly_accel.md
Name: poly_accel

Overview:
- Parametrised iterative arithmetic accelerator.
- Computes y = P(a,b) + cbrt(b) for unsigned WIDTH-bit operands, with a run-time mode select for the product term:
  - mode 0: P = a*a.
  - mode 1: P = a*b.
- Uses a start/busy/valid handshake, so results can be re-launched without reset.
- Sits as a compute leaf beside the other lab arithmetic blocks; driven by a testbench or a control FSM.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; result width is 2*WIDTH.
- CBRT_ITER, (WIDTH+2)/3, cube-root iterations (root width); derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  launch request; sampled only while busy_o=0.
- mode_i  in  1  0: a*a + cbrt(b); 1: a*b + cbrt(b); captured with operands.
- a_bi  in  WIDTH  operand a, unsigned.
- b_bi  in  WIDTH  operand b, unsigned.
- busy_o  out  1  high while an operation is in flight.
- valid_o  out  1  one-cycle pulse when y_bo is updated.
- y_bo  out  2*WIDTH  result, held until the next completion.

Behaviour:
Reset:
- rst_i=1 asynchronously forces state=IDLE, busy_o=0, valid_o=0, y_bo=0, and clears all internal registers.
- Reset mid-operation aborts the operation; no valid_o is produced for it.

States:
- IDLE:
  - On a clock edge with start_i=1, capture a_bi, b_bi and mode_i.
  - Multiplicand = a; multiplier = (mode_i ? b : a).
  - Go to RUN; busy_o=1.
- RUN, multiplier:
  - Shift-add, LSB first; one partial product per cycle.
  - Exactly WIDTH cycles, using an internal counter 0..WIDTH-1.
- RUN, cube root:
  - Runs in parallel in the sub-module over CBRT_ITER cycles.
  - Operand is b, zero-extended to 3*CBRT_ITER bits.
  - Restoring algorithm per iteration (s = 3*(k-1) down to 0): y=2y; t=(3*y*(y+1)+1)<<s; if x>=t then x-=t and y+=1.
  - Root = floor(cbrt(b)).
- Leaving RUN:
  - RUN exits when the multiplier counter reaches WIDTH-1 and the cbrt sub-module reports done. CBRT_ITER <= WIDTH always, so the multiplier dominates.
- DONE (one cycle):
  - y_bo <= product + zero-extended root.
  - valid_o=1, busy_o=0, then return to IDLE.
  - Overflow is impossible: (2^W-1)^2 + 2^CBRT_ITER < 2^(2W) for W>=2.

Latency:
- start sampled at edge t0.
- y_bo/valid_o change at edge t0+WIDTH+1.
- busy_o is high for edges t0..t0+WIDTH.

Handshake boundaries:
- start_i while busy_o=1 is ignored; operands are not re-captured.
- start_i during the DONE cycle (busy_o=0) is ignored. IDLE samples the next start, giving a minimum initiation interval of WIDTH+2 cycles.
- a_bi, b_bi and mode_i may change freely after capture.
- Zero operands are legal: a=0, b=0 gives y=0 with the same latency.

Optional Feature:
- Macro: POLY_ACCEL_CYCLE_CNT_EN.
- Defined:
  - Adds output port cyc_bo (16 bits), reset 0.
  - Free-running count of cycles spent in RUN+DONE for the most recent completed operation; updated together with valid_o.
  - Saturates at 16'hFFFF.
  - Expected value WIDTH+1.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package poly_accel_pkg contains:
  - State encoding localparams ST_IDLE, ST_RUN, ST_DONE.
  - Mode constants MODE_SQR=0, MODE_MUL=1.
  - Function cbrt_iter(width) returning (width+2)/3.
- One sub-module, poly_accel_cbrt, parametrised by WIDTH:
  - Ports: clk_i, rst_i, start_i, x_bi, busy_o, done_o, y_bo.
  - Shares the same asynchronous reset.
- The shift-add multiplier stays inline in the top.

Test Plan:
- WIDTH=8, mode 0, a=5, b=27, start pulse at t0 -> busy 9 edges; valid_o pulse at t0+9; y_bo=28.
- WIDTH=8, mode 0, a=255, b=255 -> y_bo=65031 (65025+6). Mode 1, a=12, b=100 -> y_bo=1204 (1200+4).
- Hold start_i=1 continuously with operands changing each cycle -> results correspond to operands captured at each IDLE edge; one valid_o per WIDTH+2 cycles; mid-run operand changes have no effect.
- Assert rst_i asynchronously 4 cycles into RUN -> busy_o, valid_o and y_bo go 0 immediately; no valid_o follows; next start computes correctly.
- WIDTH=16, mode 0, a=1000, b=4096 -> y_bo=1000016 at t0+17. With POLY_ACCEL_CYCLE_CNT_EN -> cyc_bo=17.
- a=0, b=0 and a=1, b=1 (mode 1) -> y_bo=0 and y_bo=2, with unchanged latency.
